// File: rtl/pbc_pkg.sv
// Shared widths, helpers and constants for the periodic displacement path.
// Imported by pbc_wrap_axis and pbc_disp_pipe.
package pbc_pkg;

    localparam int DEF_N_AXES = 3;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_TAG_W  = 16;
    localparam int DEF_CNT_W  = 32;

    // 7.5 in Q16.16
    localparam logic [31:0] BOX_7P5_Q16 = 32'h0007_8000;

    // Bit offset of axis a inside a packed per-axis vector.
    function automatic int unsigned ax_lsb(
        input int unsigned a,
        input int unsigned w
    );
        return a * w;
    endfunction

endpackage

// File: rtl/pbc_wrap_axis.sv
// One axis of the displacement path: subtract, minimum-image wrap, square.
// Ports: clk/rst, adv (shared stage enable), ref_pos/nbr_pos/box in,
//        r (wrapped displacement, S3-aligned) and sq (r*r, S3) out.
module pbc_wrap_axis
    import pbc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic [DATA_W-1:0]   ref_pos,
    input  logic [DATA_W-1:0]   nbr_pos,
    input  logic [DATA_W-1:0]   box,
    output logic [DATA_W-1:0]   r,
    output logic [2*DATA_W-1:0] sq
);

    // S1
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] box1;
    // S2
    logic [DATA_W-1:0] rw2;

    logic [DATA_W-1:0]   half;
    logic [DATA_W-1:0]   neg_half;
    logic [DATA_W-1:0]   wrapped;
    logic [2*DATA_W-1:0] rx;

    // Box is positive, so a logical shift gives floor(box/2).
    // d == +half wraps to -half so the result range is [-half, half).
    always_comb begin
        half     = box1 >> 1;
        neg_half = -half;
        wrapped  = d1;
        if ($signed(d1) >= $signed(half)) begin
            wrapped = d1 - box1;
        end else if ($signed(d1) < $signed(neg_half)) begin
            wrapped = d1 + box1;
        end
    end

    // Sign-extend so the low 2*DATA_W bits of the product are r*r exactly.
    assign rx = {{DATA_W{rw2[DATA_W-1]}}, rw2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1   <= '0;
            box1 <= '0;
            rw2  <= '0;
            r    <= '0;
            sq   <= '0;
        end else if (adv) begin
            d1   <= ref_pos - nbr_pos;
            box1 <= box;
            rw2  <= wrapped;
            r    <= rw2;
            sq   <= rx * rx;
        end
    end

endmodule

// File: rtl/pbc_disp_pipe.sv
// Pipelined minimum-image displacement: per-axis wrap, r^2, cutoff hit.
// Ports: cfg_* config load, in_* pair input (valid/ready), out_* result
//        (valid/ready), pair_cnt/hit_cnt saturating delivery counters.
module pbc_disp_pipe
    import pbc_pkg::*;
#(
    parameter int   N_AXES = DEF_N_AXES,
    parameter int   DATA_W = DEF_DATA_W,
    parameter int   FRAC_W = DEF_FRAC_W,
    parameter int   TAG_W  = DEF_TAG_W,
    parameter int   CNT_W  = DEF_CNT_W,
    localparam int  R2_W   = 2 * DATA_W + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [N_AXES*DATA_W-1:0] cfg_box,
    input  logic [R2_W-1:0]          cfg_cut2,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_AXES*DATA_W-1:0] in_ref,
    input  logic [N_AXES*DATA_W-1:0] in_nbr,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_AXES*DATA_W-1:0] out_r,
    output logic [R2_W-1:0]          out_r2,
    output logic                     out_hit,
    output logic [TAG_W-1:0]         out_tag,
    output logic [CNT_W-1:0]         pair_cnt,
    output logic [CNT_W-1:0]         hit_cnt
);

    if (FRAC_W >= DATA_W) begin : g_bad_frac
        $error("FRAC_W must be smaller than DATA_W");
    end

    logic                     advance;
    logic                     xfer;

    logic [N_AXES*DATA_W-1:0] box_q;
    logic [R2_W-1:0]          cut_q;

    logic                     v1, v2, v3;
    logic [R2_W-1:0]          cut1, cut2s, cut3;
    logic [TAG_W-1:0]         tag1, tag2, tag3;

    logic [N_AXES*DATA_W-1:0] r3;
    logic [2*DATA_W-1:0]      sq3 [N_AXES];
    logic [R2_W-1:0]          sum;

    // Single global stall: every stage moves together, bubbles stay put.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign xfer     = out_valid & out_ready;

    for (genvar a = 0; a < N_AXES; a++) begin : g_axis
        pbc_wrap_axis #(
            .DATA_W (DATA_W)
        ) u_axis (
            .clk     (clk),
            .rst     (rst),
            .adv     (advance),
            .ref_pos (in_ref[ax_lsb(a, DATA_W) +: DATA_W]),
            .nbr_pos (in_nbr[ax_lsb(a, DATA_W) +: DATA_W]),
            .box     (box_q[ax_lsb(a, DATA_W) +: DATA_W]),
            .r       (r3[ax_lsb(a, DATA_W) +: DATA_W]),
            .sq      (sq3[a])
        );
    end

    always_comb begin
        sum = '0;
        for (int a = 0; a < N_AXES; a++) begin
            sum = sum + R2_W'(sq3[a]);
        end
    end

    // Config registers; S1 samples the pre-write value on a write cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_q <= '0;
            cut_q <= '0;
        end else if (cfg_we) begin
            box_q <= cfg_box;
            cut_q <= cfg_cut2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            cut1      <= '0;
            cut2s     <= '0;
            cut3      <= '0;
            tag1      <= '0;
            tag2      <= '0;
            tag3      <= '0;
            out_r     <= '0;
            out_r2    <= '0;
            out_hit   <= 1'b0;
            out_tag   <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            cut1      <= cut_q;
            cut2s     <= cut1;
            cut3      <= cut2s;
            tag1      <= in_tag;
            tag2      <= tag1;
            tag3      <= tag2;
            out_r     <= r3;
            out_r2    <= sum;
            out_hit   <= (sum < cut3);
            out_tag   <= tag3;
        end
    end

    // A config write clears the counters and overrides a same-cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt <= '0;
            hit_cnt  <= '0;
        end else if (cfg_we) begin
            pair_cnt <= '0;
            hit_cnt  <= '0;
        end else if (xfer) begin
            if (pair_cnt != '1) begin
                pair_cnt <= pair_cnt + 1'b1;
            end
            if (out_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end

endmodule
